// File: rtl/banco_wr_arbiter.sv
// ----------------------------------------------------------------------------
// banco_wr_arbiter
//
// Shares the single write port of the register bank (addrW/datW/RegWrite)
// between NREQ requesters and adds a clear sequencer that sweeps every bank
// address, writing CLR_VAL to each one. All bank-facing outputs are
// registered, so the write port never glitches.
//
// Handshake (valid/ready): req[i] is "valid" and is held with its address and
// data slices until gnt[i] pulses for one cycle. The gnt pulse coincides with
// the bank write of that requester's data; the requester drops (or renews)
// req on the following cycle. At most one grant is issued per cycle, so
// back-to-back writes from different requesters are possible.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active low
//   req        in   [NREQ]            write request per requester
//   req_addr   in   [NREQ*BIT_ADDR]   requester i address at [i*BIT_ADDR +: BIT_ADDR]
//   req_dat    in   [NREQ*BIT_DATO]   requester i data at [i*BIT_DATO +: BIT_DATO]
//   gnt        out  [NREQ]            one-hot, one-cycle grant pulse
//   clr_start  in   clear sweep request pulse (ignored while sweeping)
//   busy       out  high while the clear sweep writes the bank
//   clr_done   out  one-cycle pulse after the last clear write
//   addrW      out  [BIT_ADDR]        bank write address
//   datW       out  [BIT_DATO]        bank write data
//   RegWrite   out  bank write enable
//   dbg_state  out  FSM state for observation (1 = CLEAR, 0 = IDLE)
//
// Build option:
//   BANCO_ARB_FIXED_PRIO_EN  when defined, the lowest asserted requester index
//                            always wins and the round-robin pointer is frozen.
//                            Undefined (default): round-robin arbitration.
// ----------------------------------------------------------------------------
module banco_wr_arbiter #(
    parameter int                  BIT_ADDR = 8,
    parameter int                  BIT_DATO = 4,
    parameter int                  NREQ     = 2,
    parameter logic [BIT_DATO-1:0] CLR_VAL  = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*BIT_ADDR-1:0] req_addr,
    input  logic [NREQ*BIT_DATO-1:0] req_dat,
    output logic [NREQ-1:0]          gnt,
    input  logic                     clr_start,
    output logic                     busy,
    output logic                     clr_done,
    output logic [BIT_ADDR-1:0]      addrW,
    output logic [BIT_DATO-1:0]      datW,
    output logic                     RegWrite,
    output logic                     dbg_state
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Terminal sweep count NREG-1; cnt carries one extra bit so this compare
    // never sees a wrapped value.
    localparam logic [BIT_ADDR:0] CNT_LAST = {1'b0, {BIT_ADDR{1'b1}}};
    localparam logic [LW-1:0]     LAST_RST = LW'(NREQ - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [BIT_ADDR:0]     cnt_q, cnt_d;
    logic [LW-1:0]         last_q, last_d;

    logic [NREQ-1:0]       gnt_q, gnt_d;
    logic                  we_q, we_d;
    logic [BIT_ADDR-1:0]   addr_q, addr_d;
    logic [BIT_DATO-1:0]   dat_q, dat_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // Arbitration result for the current cycle.
    logic                  win_found;
    logic [LW-1:0]         win_idx;
    logic [LW-1:0]         cand;
    logic [BIT_ADDR-1:0]   win_addr;
    logic [BIT_DATO-1:0]   win_dat;

    // ------------------------------------------------------------------
    // Arbiter: scan candidates in descending priority order so the last
    // hit is the highest-priority requester.
    // ------------------------------------------------------------------
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
`ifdef BANCO_ARB_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = LW'(i);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
`else
        // Priority order is last+1, last+2, ..., last (mod NREQ).
        for (int off = NREQ; off >= 1; off--) begin
            cand = LW'((int'(last_q) + off) % NREQ);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
`endif
    end

    // Constant-base slice selection keeps the mux free of variable part-selects.
    always_comb begin
        win_addr = '0;
        win_dat  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (LW'(i) == win_idx) begin
                win_addr = req_addr[i*BIT_ADDR +: BIT_ADDR];
                win_dat  = req_dat[i*BIT_DATO +: BIT_DATO];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM process 1: state and output registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            last_q  <= LAST_RST;
            gnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            dat_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            dat_q   <= dat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next state and sweep counter. cnt holds the address
    // being written by the sweep in the current cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (clr_start) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: next values of the registered outputs. A sweep write
    // takes the port whenever the next state is CLEAR; otherwise the
    // arbiter may grant, including on the edge that ends the sweep.
    // ------------------------------------------------------------------
    always_comb begin
        gnt_d  = '0;
        we_d   = 1'b0;
        addr_d = addr_q;
        dat_d  = dat_q;
        busy_d = 1'b0;
        last_d = last_q;
        done_d = (state_q == S_CLEAR) && (state_d == S_IDLE);

        if (state_d == S_CLEAR) begin
            we_d   = 1'b1;
            addr_d = cnt_d[BIT_ADDR-1:0];
            dat_d  = CLR_VAL;
            busy_d = 1'b1;
        end else if (win_found) begin
            gnt_d[win_idx] = 1'b1;
            we_d           = 1'b1;
            addr_d         = win_addr;
            dat_d          = win_dat;
`ifndef BANCO_ARB_FIXED_PRIO_EN
            last_d         = win_idx;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign RegWrite  = we_q;
    assign addrW     = addr_q;
    assign datW      = dat_q;
    assign busy      = busy_q;
    assign clr_done  = done_q;
    assign dbg_state = (state_q == S_CLEAR);

endmodule

// File: tb/tb_banco_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_banco_wr_arbiter
//
// Bench for banco_wr_arbiter. A behavioural model updated on each rising edge
// pushes the expected output tuple into exp_q; each scenario task pops it on
// the falling edge and compares against the DUT, adding its own scenario
// checks. Respects BANCO_ARB_FIXED_PRIO_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_banco_wr_arbiter;

    localparam int                  BIT_ADDR = 8;
    localparam int                  BIT_DATO = 4;
    localparam int                  NREQ     = 2;
    localparam logic [BIT_DATO-1:0] CLR_VAL  = 4'h6;
    localparam int                  NREG     = 2 ** BIT_ADDR;
    localparam int                  W        = NREQ + 1 + BIT_ADDR + BIT_DATO + 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NREQ-1:0]          req;
    logic [NREQ*BIT_ADDR-1:0] req_addr;
    logic [NREQ*BIT_DATO-1:0] req_dat;
    logic                     clr_start;
    logic [NREQ-1:0]          gnt;
    logic                     busy;
    logic                     clr_done;
    logic [BIT_ADDR-1:0]      addrW;
    logic [BIT_DATO-1:0]      datW;
    logic                     RegWrite;
    logic                     dbg_state;

    banco_wr_arbiter #(
        .BIT_ADDR (BIT_ADDR),
        .BIT_DATO (BIT_DATO),
        .NREQ     (NREQ),
        .CLR_VAL  (CLR_VAL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_addr  (req_addr),
        .req_dat   (req_dat),
        .gnt       (gnt),
        .clr_start (clr_start),
        .busy      (busy),
        .clr_done  (clr_done),
        .addrW     (addrW),
        .datW      (datW),
        .RegWrite  (RegWrite),
        .dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    logic [W-1:0]        exp_q[$];
    bit                  m_sweep;
    int                  m_left;
    int                  m_last;
    logic [BIT_ADDR-1:0] m_addr;
    logic [BIT_DATO-1:0] m_dat;

    function automatic logic [W-1:0] pack(input logic [NREQ-1:0] g, input logic we,
                                          input logic [BIT_ADDR-1:0] a,
                                          input logic [BIT_DATO-1:0] d,
                                          input logic b, input logic dn, input logic st);
        return {g, we, a, d, b, dn, st};
    endfunction

    function automatic logic [W-1:0] observed();
        return pack(gnt, RegWrite, addrW, datW, busy, clr_done, dbg_state);
    endfunction

    function automatic void m_reset();
        m_sweep = 1'b0;
        m_left  = 0;
        m_last  = NREQ - 1;
        m_addr  = '0;
        m_dat   = '0;
        exp_q.delete();
    endfunction

    // Requester chosen for a write, or -1 when nobody asks.
    function automatic int pick();
        if (req == '0) return -1;
`ifdef BANCO_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (req[i]) return i;
`else
        for (int k = 1; k <= NREQ; k++) if (req[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
`endif
        return -1;
    endfunction

    function automatic void model_edge();
        logic [NREQ-1:0] g;
        logic we, bz, dn;
        int w;
        g = '0; we = 1'b0; bz = 1'b0; dn = 1'b0; w = -1;
        if (!rst) begin
            m_reset();
        end else if (m_sweep && m_left == 0) begin
            m_sweep = 1'b0;
            dn = 1'b1;
            w = pick();
        end else if (m_sweep) begin
            m_left = m_left - 1;
            m_addr = m_addr + 1'b1;
            m_dat = CLR_VAL;
            we = 1'b1; bz = 1'b1;
        end else if (clr_start) begin
            m_sweep = 1'b1;
            m_left = NREG - 1;
            m_addr = '0;
            m_dat = CLR_VAL;
            we = 1'b1; bz = 1'b1;
        end else begin
            w = pick();
        end
        if (w >= 0) begin
            g[w] = 1'b1;
            we = 1'b1;
            m_addr = req_addr[w*BIT_ADDR +: BIT_ADDR];
            m_dat = req_dat[w*BIT_DATO +: BIT_DATO];
`ifndef BANCO_ARB_FIXED_PRIO_EN
            m_last = w;
`endif
        end
        exp_q.push_back(pack(g, we, m_addr, m_dat, bz, dn, m_sweep));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req = '0;
        req_addr = '0;
        req_dat = '0;
        clr_start = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [W-1:0] e;
        rst = 1'b1;
        idle_inputs();
        #3 rst = 1'b0;
        m_reset();
        #1;
        n_checks++;
        if (observed() !== '0) begin
            n_errors++;
            $display("FAIL reset_initial: got=%h exp=0", observed());
        end
        @(negedge clk);
        rst = 1'b1;
        req = 2'b01;
        req_addr[0 +: BIT_ADDR] = 8'h05;
        req_dat[0 +: BIT_DATO] = 4'hA;
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (observed() !== e) begin
            n_errors++;
            $display("FAIL reset_first_grant: got=%h exp=%h", observed(), e);
        end
        n_checks++;
        if (gnt !== 2'b01 || RegWrite !== 1'b1 || addrW !== 8'h05 || datW !== 4'hA) begin
            n_errors++;
            $display("FAIL reset_first_grant_fields: gnt=%b we=%b addr=%h dat=%h exp 01/1/05/a",
                     gnt, RegWrite, addrW, datW);
        end
        // Outputs are non-zero now; reset in mid-cycle must clear them at once.
        idle_inputs();
        #2 rst = 1'b0;
        m_reset();
        #1;
        n_checks++;
        if (observed() !== '0) begin
            n_errors++;
            $display("FAIL reset_midcycle: got=%h exp=0", observed());
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_contention();
        logic [W-1:0]    e;
        logic [NREQ-1:0] g_exp;
        req = 2'b11;
        req_addr = {8'h20, 8'h10};
        req_dat = {4'h2, 4'h1};
        for (int i = 0; i < 6; i++) begin
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (observed() !== e) begin
                n_errors++;
                $display("FAIL contention_model cyc%0d: got=%h exp=%h", i, observed(), e);
            end
`ifdef BANCO_ARB_FIXED_PRIO_EN
            g_exp = 2'b01;
`else
            g_exp = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
            n_checks++;
            if (gnt !== g_exp || RegWrite !== 1'b1 || addrW !== (g_exp[0] ? 8'h10 : 8'h20)) begin
                n_errors++;
                $display("FAIL contention_pattern cyc%0d: gnt=%b we=%b addr=%h exp gnt=%b",
                         i, gnt, RegWrite, addrW, g_exp);
            end
        end
        idle_inputs();
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (observed() !== e) begin
            n_errors++;
            $display("FAIL contention_release: got=%h exp=%h", observed(), e);
        end
    endtask

    task automatic test_clear();
        logic [W-1:0] e;
        int n_wr, n_done;
        n_wr = 0;
        n_done = 0;
        clr_start = 1'b1;
        for (int i = 0; i < NREG + 3; i++) begin
            tick();
            clr_start = 1'b0;
            e = exp_q.pop_front();
            n_checks++;
            if (observed() !== e) begin
                n_errors++;
                $display("FAIL clear_model cyc%0d: got=%h exp=%h", i, observed(), e);
            end
            if (i < NREG && (RegWrite !== 1'b1 || busy !== 1'b1 || addrW !== BIT_ADDR'(i) || datW !== CLR_VAL)) begin
                n_errors++;
                $display("FAIL clear_write cyc%0d: we=%b busy=%b addr=%h dat=%h", i, RegWrite, busy, addrW, datW);
            end
            if (RegWrite === 1'b1 && busy === 1'b1) n_wr++;
            if (clr_done === 1'b1) n_done++;
        end
        n_checks++;
        if (n_wr != NREG || n_done != 1) begin
            n_errors++;
            $display("FAIL clear_counts: writes=%0d done=%0d exp %0d/1", n_wr, n_done, NREG);
        end
    endtask

    task automatic test_clr_vs_req();
        logic [W-1:0] e;
        bit granted, gnt_on_done;
        granted = 1'b0;
        gnt_on_done = 1'b0;
        clr_start = 1'b1;
        req = 2'b10;
        req_addr[BIT_ADDR +: BIT_ADDR] = 8'h33;
        req_dat[BIT_DATO +: BIT_DATO] = 4'hC;
        for (int i = 0; i < NREG + 6 && !granted; i++) begin
            tick();
            clr_start = 1'b0;
            e = exp_q.pop_front();
            n_checks++;
            if (observed() !== e) begin
                n_errors++;
                $display("FAIL clr_vs_req_model cyc%0d: got=%h exp=%h", i, observed(), e);
            end
            if (busy === 1'b1 && gnt !== '0) begin
                n_errors++;
                $display("FAIL clr_vs_req_gnt_busy cyc%0d: gnt=%b exp 00", i, gnt);
            end
            if (gnt === 2'b10) begin
                granted = 1'b1;
                gnt_on_done = (clr_done === 1'b1) && (addrW === 8'h33) && (datW === 4'hC);
                req = '0;
            end
        end
        n_checks++;
        if (!granted || !gnt_on_done) begin
            n_errors++;
            $display("FAIL clr_vs_req_final: granted=%0d with_done=%0d exp 1/1", granted, gnt_on_done);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_sweep();
        logic [W-1:0] e;
        bit reached;
        reached = 1'b0;
        clr_start = 1'b1;
        for (int i = 0; i < 10 && !reached; i++) begin
            tick();
            clr_start = 1'b0;
            e = exp_q.pop_front();
            n_checks++;
            if (observed() !== e) begin
                n_errors++;
                $display("FAIL mid_sweep_model cyc%0d: got=%h exp=%h", i, observed(), e);
            end
            if (addrW === 8'h03 && busy === 1'b1) reached = 1'b1;
        end
        n_checks++;
        if (!reached) begin
            n_errors++;
            $display("FAIL mid_sweep_reach: addrW=%h busy=%b exp 03/1", addrW, busy);
        end
        #2 rst = 1'b0;
        m_reset();
        #1;
        n_checks++;
        if (RegWrite !== 1'b0 || busy !== 1'b0 || clr_done !== 1'b0 || dbg_state !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_sweep_abort: we=%b busy=%b done=%b st=%b exp 0", RegWrite, busy, clr_done, dbg_state);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (observed() !== e || clr_done !== 1'b0) begin
                n_errors++;
                $display("FAIL mid_sweep_after cyc%0d: got=%h exp=%h", i, observed(), e);
            end
        end
        req = 2'b01;
        req_addr[0 +: BIT_ADDR] = 8'h44;
        req_dat[0 +: BIT_DATO] = 4'h5;
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (observed() !== e || gnt !== 2'b01 || addrW !== 8'h44) begin
            n_errors++;
            $display("FAIL mid_sweep_regrant: got=%h exp=%h", observed(), e);
        end
        idle_inputs();
        tick();
        void'(exp_q.pop_front());
    endtask

    task automatic test_random();
        logic [W-1:0] e;
        idle_inputs();
        for (int i = 0; i < 600; i++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (gnt[r] === 1'b1) begin
                    req[r] = 1'b0;
                end else if (req[r] == 1'b0 && $urandom_range(0, 2) == 0) begin
                    req[r] = 1'b1;
                    req_addr[r*BIT_ADDR +: BIT_ADDR] = BIT_ADDR'($urandom);
                    req_dat[r*BIT_DATO +: BIT_DATO] = BIT_DATO'($urandom);
                end
            end
            clr_start = ($urandom_range(0, 119) == 0);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (observed() !== e) begin
                n_errors++;
                $display("FAIL random cyc%0d: got=%h exp=%h req=%b", i, observed(), e, req);
            end
        end
        idle_inputs();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_contention();
        test_clear();
        test_clr_vs_req();
        test_reset_mid_sweep();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
